// File: rtl/rr_arb_pkg.sv
// Shared types, widths and the winner-search helper for the 16-way round-robin arbiter.
package rr_arb_pkg;

   localparam int unsigned NUM_REQ = 16;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned HOLD_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1
   } state_e;

   typedef struct packed {
      logic              found;
      logic [ADDR_W-1:0] index;
   } win_t;

   // First set request at or after ptr, ascending with wrap 15->0.
   // Walking the offsets downward lets the smallest offset overwrite last.
   function automatic win_t next_winner(input logic [NUM_REQ-1:0] req,
                                        input logic [ADDR_W-1:0]  ptr);
      win_t              w;
      logic [ADDR_W-1:0] idx;
      w = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ptr + ADDR_W'(i);
         if (req[idx]) begin
            w.found = 1'b1;
            w.index = idx;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/dec_4_to_16.sv
// Plain 4-to-16 binary-to-one-hot decoder.
module dec_4_to_16 (
   input  logic [3:0]  i_addr,
   output logic [15:0] o_dec
);

   // One bit set at the position given by the address.
   always_comb begin
      o_dec = 16'h0001 << i_addr;
   end

endmodule

// File: rtl/rr_arb_16.sv
// 16-requester round-robin arbiter with bounded hold time and a registered winner address.
module rr_arb_16
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NUM_REQ-1:0]  REQ,
   output logic                GNT_VALID,
   output logic [ADDR_W-1:0]   ADDR,
   output logic [NUM_REQ-1:0]  DEC,
   output logic [HOLD_W-1:0]   HOLD_CNT
);

   localparam logic [HOLD_W-1:0] LP_MAX_HOLD = HOLD_W'(MAX_HOLD);

   state_e              r_state;
   logic                r_gnt_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_ptr;
   logic [HOLD_W-1:0]   r_hold_cnt;

   logic [ADDR_W-1:0]   w_search_ptr;
   win_t                w_win;
   logic                w_keep;
   logic [NUM_REQ-1:0]  w_dec_raw;

   // A release edge searches from just past the current grantee, not the stale pointer.
   always_comb begin
      w_search_ptr = (r_state == GRANT) ? (r_addr + ADDR_W'(1)) : r_ptr;
      w_win        = next_winner(REQ, w_search_ptr);
      w_keep       = REQ[r_addr] && (r_hold_cnt < LP_MAX_HOLD);
   end

   // Arbitration FSM: pointer, grantee address and hold counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= IDLE;
         r_gnt_valid <= 1'b0;
         r_addr      <= '0;
         r_ptr       <= '0;
         r_hold_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_win.found) begin
                  r_addr      <= w_win.index;
                  r_gnt_valid <= 1'b1;
                  r_hold_cnt  <= HOLD_W'(1);
                  r_state     <= GRANT;
               end
            end
            GRANT: begin
               if (w_keep) begin
                  r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
               end else begin
                  r_ptr <= r_addr + ADDR_W'(1);
                  if (w_win.found) begin
                     r_addr     <= w_win.index;
                     r_hold_cnt <= HOLD_W'(1);
                  end else begin
                     r_gnt_valid <= 1'b0;
                     r_hold_cnt  <= '0;
                     r_state     <= IDLE;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_gnt_valid <= 1'b0;
               r_hold_cnt  <= '0;
            end
         endcase
      end
   end

   dec_4_to_16 u_dec (
      .i_addr (r_addr),
      .o_dec  (w_dec_raw)
   );

   // Gate the decoded address so the strobe bus is all zero whenever no grant is active.
   always_comb begin
      DEC = w_dec_raw & {NUM_REQ{r_gnt_valid}};
   end

   assign GNT_VALID = r_gnt_valid;
   assign ADDR      = r_addr;
   assign HOLD_CNT  = r_hold_cnt;

endmodule

// File: tb/tb_rr_arb_16.sv
// Self-checking bench for rr_arb_16: directed scenarios plus randomized traffic against a rule-level model.
module tb_rr_arb_16;

   logic        clk;
   logic        rst;
   logic [15:0] req8, req2;
   logic        gv8, gv2;
   logic [3:0]  addr8, addr2;
   logic [15:0] dec8, dec2;
   logic [7:0]  cnt8, cnt2;

   logic [28:0] obs8, obs2;
   assign obs8 = {gv8, addr8, dec8, cnt8};
   assign obs2 = {gv2, addr2, dec2, cnt2};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, index 0 = MAX_HOLD 8 instance, index 1 = MAX_HOLD 2 instance.
   bit   m_valid [2];
   int   m_addr  [2];
   int   m_cnt   [2];
   int   m_ptr   [2];
   int   maxh    [2] = '{8, 2};

   rr_arb_16 #(.MAX_HOLD(8)) u_dut8 (
      .CLK(clk), .RST(rst), .REQ(req8),
      .GNT_VALID(gv8), .ADDR(addr8), .DEC(dec8), .HOLD_CNT(cnt8)
   );

   rr_arb_16 #(.MAX_HOLD(2)) u_dut2 (
      .CLK(clk), .RST(rst), .REQ(req2),
      .GNT_VALID(gv2), .ADDR(addr2), .DEC(dec2), .HOLD_CNT(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int find_from(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++) begin
         if (r[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0; m_addr[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input logic [15:0] r);
      int w;
      if (!m_valid[k]) begin
         w = find_from(r, m_ptr[k]);
         if (w >= 0) begin
            m_valid[k] = 1'b1; m_addr[k] = w; m_cnt[k] = 1;
         end
      end else if (r[m_addr[k]] && m_cnt[k] < maxh[k]) begin
         m_cnt[k] = m_cnt[k] + 1;
      end else begin
         m_ptr[k] = (m_addr[k] + 1) % 16;
         w = find_from(r, m_ptr[k]);
         if (w >= 0) begin
            m_addr[k] = w; m_cnt[k] = 1;
         end else begin
            m_valid[k] = 1'b0; m_cnt[k] = 0;
         end
      end
   endtask

   function automatic logic [28:0] exp_of(input int k);
      logic [15:0] d;
      d = m_valid[k] ? (16'h0001 << m_addr[k]) : 16'h0000;
      return {m_valid[k], 4'(m_addr[k]), d, 8'(m_cnt[k])};
   endfunction

   // One clock: advance the model with the sampled requests, then settle 1 time unit past the edge.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         model_step(0, req8);
         model_step(1, req2);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req8 = 16'hFFFF; req2 = 16'hFFFF;
      model_reset();
      tick(); tick();
      n_checks += 2;
      if (obs8 !== 29'h0) begin n_fail++; $display("FAIL reset_hold8: got %h want %h", obs8, 29'h0); end
      if (obs2 !== 29'h0) begin n_fail++; $display("FAIL reset_hold2: got %h want %h", obs2, 29'h0); end
      rst = 1'b0; req8 = 16'h0; req2 = 16'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks += 2;
         if (obs8 !== 29'h0) begin n_fail++; $display("FAIL idle8 cyc%0d: got %h want %h", i, obs8, 29'h0); end
         if (obs2 !== 29'h0) begin n_fail++; $display("FAIL idle2 cyc%0d: got %h want %h", i, obs2, 29'h0); end
      end
   endtask

   task automatic test_single();
      logic [28:0] e;
      req8 = 16'h0020;
      for (int i = 1; i <= 3; i++) begin
         tick();
         e = {1'b1, 4'd5, 16'h0020, 8'(i)};
         n_checks++;
         if (obs8 !== e) begin n_fail++; $display("FAIL single cyc%0d: got %h want %h", i, obs8, e); end
      end
      req8 = 16'h0;
      tick();
      e = {1'b0, 4'd5, 16'h0000, 8'd0};
      n_checks++;
      if (obs8 !== e) begin n_fail++; $display("FAIL single_drop: got %h want %h", obs8, e); end
      // Pointer now at 6: with requests 0 and 6 pending, 6 must win.
      req8 = 16'h0041;
      tick();
      e = {1'b1, 4'd6, 16'h0040, 8'd1};
      n_checks++;
      if (obs8 !== e) begin n_fail++; $display("FAIL single_ptr: got %h want %h", obs8, e); end
      req8 = 16'h0;
      tick();
   endtask

   task automatic test_rotation();
      logic [28:0] e;
      logic [3:0]  a;
      req2 = 16'h8001;
      for (int i = 0; i < 8; i++) begin
         tick();
         a = ((i / 2) % 2 != 0) ? 4'd15 : 4'd0;
         e = {1'b1, a, 16'h0001 << a, 8'((i % 2) + 1)};
         n_checks++;
         if (obs2 !== e) begin n_fail++; $display("FAIL rotation cyc%0d: got %h want %h", i, obs2, e); end
      end
      req2 = 16'h0;
      tick();
   endtask

   task automatic test_wrap();
      logic [28:0] e;
      req8 = 16'h8000;
      for (int i = 1; i <= 8; i++) begin
         tick();
         e = {1'b1, 4'd15, 16'h8000, 8'(i)};
         n_checks++;
         if (obs8 !== e) begin n_fail++; $display("FAIL wrap_hold cyc%0d: got %h want %h", i, obs8, e); end
      end
      req8 = 16'h8004;
      tick();
      e = {1'b1, 4'd2, 16'h0004, 8'd1};
      n_checks++;
      if (obs8 !== e) begin n_fail++; $display("FAIL wrap_winner: got %h want %h", obs8, e); end
      req8 = 16'h0;
      tick();
   endtask

   task automatic test_timeout();
      logic [28:0] e;
      req8 = 16'h0100;
      for (int i = 0; i < 20; i++) begin
         tick();
         e = {1'b1, 4'd8, 16'h0100, 8'((i % 8) + 1)};
         n_checks++;
         if (obs8 !== e) begin n_fail++; $display("FAIL timeout cyc%0d: got %h want %h", i, obs8, e); end
      end
      req8 = 16'h0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [28:0] e;
      req8 = 16'h0200;
      for (int i = 0; i < 4; i++) tick();
      e = {1'b1, 4'd9, 16'h0200, 8'd4};
      n_checks++;
      if (obs8 !== e) begin n_fail++; $display("FAIL midrst_pre: got %h want %h", obs8, e); end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (obs8 !== 29'h0) begin n_fail++; $display("FAIL midrst_async: got %h want %h", obs8, 29'h0); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      e = {1'b1, 4'd9, 16'h0200, 8'd1};
      n_checks++;
      if (obs8 !== e) begin n_fail++; $display("FAIL midrst_regrant: got %h want %h", obs8, e); end
      req8 = 16'h0;
      tick();
   endtask

   task automatic test_random();
      logic [28:0] e8, e2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) req8 = 16'($urandom) & 16'($urandom);
         if ($urandom_range(3) == 0) req2 = 16'($urandom) & 16'($urandom) & 16'($urandom);
         if ($urandom_range(15) == 0) req8 = 16'h0;
         tick();
         e8 = exp_of(0);
         e2 = exp_of(1);
         n_checks += 3;
         if (obs8 !== e8) begin n_fail++; $display("FAIL random8 cyc%0d: got %h want %h", i, obs8, e8); end
         if (obs2 !== e2) begin n_fail++; $display("FAIL random2 cyc%0d: got %h want %h", i, obs2, e2); end
         if ($countones(dec8) > 1 || ((dec8 != 16'h0) != gv8)) begin
            n_fail++; $display("FAIL onehot cyc%0d: got dec %h valid %b want one-hot iff valid", i, dec8, gv8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb_16.md
Name: rr_arb_16

Overview:
- 16-requester round-robin arbiter for a single shared resource.
- Registers a 4-bit winner address and expands it to a one-hot grant through the existing 4-to-16 decoder.
- Sits between 16 requesting agents and the shared resource; each agent's resource-select strobe is one bit of DEC.
- Bounded hold time, so no requester can starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may keep the grant; legal range 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  16  request vector; bit i = requester i wants the resource.
- GNT_VALID  out  1  a grant is active this cycle.
- ADDR  out  4  index of the current grantee; holds its last value while GNT_VALID=0.
- DEC  out  16  one-hot grant = decode(ADDR) AND GNT_VALID; all zero when idle.
- HOLD_CNT  out  8  cycles the current grant has been held, 1-based; 0 when idle.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous and active-high, named RST; the clock is named CLK.
  - While RST=1: state=IDLE, GNT_VALID=0, ADDR=0, DEC=0, HOLD_CNT=0, priority pointer PTR=0.
  - RST may assert at any time, including mid-grant; the grant drops immediately and asynchronously.
- States: IDLE, GRANT (2-bit encoding).
- Winner selection (combinational):
  - Search REQ starting at PTR, ascending, wrapping 15->0.
  - The first set bit wins.
  - No set bit means no winner.
- IDLE:
  - If REQ!=0 at a rising edge: ADDR<=winner, GNT_VALID<=1, HOLD_CNT<=1, go to GRANT.
  - Latency is one cycle from REQ sampled to DEC asserted.
  - If REQ=0: stay in IDLE; all outputs unchanged.
- GRANT, evaluated each rising edge:
  - Keep: REQ[ADDR]=1 and HOLD_CNT<MAX_HOLD. Then HOLD_CNT<=HOLD_CNT+1 and ADDR is unchanged.
  - Release: REQ[ADDR]=0, or HOLD_CNT==MAX_HOLD. Then PTR<=ADDR+1 (mod 16, 15 wraps to 0).
  - The release-edge winner search uses the new pointer value (ADDR+1), not the old PTR.
  - If a winner exists under the new pointer: grant it back-to-back with no idle cycle; ADDR<=winner, HOLD_CNT<=1, remain in GRANT.
  - If no winner exists: GNT_VALID<=0, HOLD_CNT<=0, go to IDLE; ADDR keeps its last value.
- Boundary rules:
  - A timed-out requester that is the only requester is re-granted immediately, HOLD_CNT restarts at 1.
  - MAX_HOLD=1 gives strict per-cycle rotation among active requesters.
  - Requests that change during a kept grant are ignored until the release edge.
  - DEC is never multi-hot. DEC!=0 if and only if GNT_VALID=1.
  - X on REQ bits other than the search target does not matter (not a functional requirement).

Decomposition:
- Package rr_arb_pkg:
  - NUM_REQ=16, ADDR_W=4, HOLD_W=8.
  - State typedef {IDLE, GRANT}.
  - Function next_winner(req, ptr) returning {found, index}.
- Sub-module: existing dec_4_to_16, instantiated once.
  - ADDR feeds it; its output is ANDed with GNT_VALID to form DEC.
- Everything else (FSM, pointer, hold counter) stays in rr_arb_16.

Test Plan:
1. Reset and idle:
   - Stimulus: RST=1 with REQ=16'hFFFF; release RST with REQ=0 for 5 cycles.
   - Response: DEC=0, GNT_VALID=0, ADDR=0, HOLD_CNT=0 throughout.
2. Single request:
   - Stimulus: REQ=16'h0020 held 3 cycles, then 0.
   - Response: one cycle later DEC=16'h0020, ADDR=5, HOLD_CNT 1,2,3; the edge after REQ drops gives DEC=0; PTR=6.
3. Round-robin rotation:
   - Stimulus: REQ=16'h8001 constant, MAX_HOLD=2.
   - Response: grants alternate ADDR 0,0,15,15,0,0,... with no gap cycles.
4. Wrap-around and pointer:
   - Stimulus: after a grant to 15, REQ=16'h8004.
   - Response: PTR=0, next winner ADDR=2, not 15.
5. Hold timeout with sole requester:
   - Stimulus: REQ=16'h0100 held 20 cycles, MAX_HOLD=8.
   - Response: GNT_VALID stays 1; HOLD_CNT counts 1..8 and restarts at 1 continuously; DEC=16'h0100 throughout.
6. Reset mid-grant:
   - Stimulus: assert RST asynchronously between edges while ADDR=9, HOLD_CNT=4.
   - Response: DEC=0, GNT_VALID=0, ADDR=0, HOLD_CNT=0 within the same cycle, before the next edge; after release, REQ=16'h0200 is granted with HOLD_CNT=1.
